apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
- Synthesizable APB requester: the initiator end of the APB bus that the slave-side monitor observes.
- Accepts one command at a time on a valid/ready command port and drives the APB SETUP/ACCESS phases.
- Waits on pready with a bounded timeout.
- Returns read data, error and wait-state count on a one-cycle response strobe.
- Sits between the testbench or host sequencer and the APB interface signals.

Parameters:
ADDR_W, 32, paddr/cmd_addr width
DATA_W, 32, pwdata/prdata width
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  ADDR_W  transfer address
cmd_write  in  1  1=write, 0=read
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  DATA_W  read data (0 for writes/timeout)
rsp_slverr  out  1  pslverr sampled at completion, or 1 on timeout
rsp_timeout  out  1  transfer aborted by timeout
rsp_wait  out  32  ACCESS cycles spent with pready low (saturating)
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset (async, rst=1): state IDLE; psel, penable, paddr, pwrite, pwdata all 0; rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, rsp_wait all 0; wait counter 0. Asserting rst mid-transfer drops psel/penable immediately; no response is generated.
- States:
  - IDLE: cmd_ready=1, psel=0, penable=0. On cmd_valid: latch addr/write/wdata into paddr/pwrite/pwdata; go to SETUP; clear wait counter.
  - SETUP (exactly 1 cycle): psel=1, penable=0; go to ACCESS.
  - ACCESS: psel=1, penable=1.
    - pready=1: complete; go to IDLE.
    - pready=0: increment wait counter, saturating at 32'hFFFF_FFFF.
    - TIMEOUT!=0 and counter==TIMEOUT with pready=0: abort; go to IDLE.
- cmd_ready is high only in IDLE. Minimum transfer is 2 bus cycles plus 1 idle cycle between back-to-back commands.
- Response: registered; rsp_valid=1 for exactly one cycle, the cycle after completion or abort (coincides with the IDLE cycle).
  - Read: rsp_rdata=prdata sampled with pready.
  - Write: rsp_rdata=0.
  - rsp_slverr=pslverr sampled only when pready=1. pslverr is ignored otherwise.
  - Timeout: rsp_timeout=1, rsp_slverr=1, rsp_rdata=0.
  - rsp_wait=final counter value.
  - Response fields hold their values until the next response.
- paddr/pwrite/pwdata are stable from SETUP through the completing ACCESS cycle, and hold their last values while IDLE.
- cmd_* changes while not accepted are ignored. cmd_valid seen in non-IDLE states has no effect.
- pready high during SETUP is ignored.

Test Plan:
- Zero-wait write:
  - Stimulus: cmd addr=0x10, wdata=0xDEADBEEF, write=1; slave holds pready=1.
  - Response: psel high 2 cycles, penable high on 2nd; rsp_valid 1 cycle later with slverr=0, wait=0, rdata=0.
- Read with 3 wait states:
  - Stimulus: addr=0x24; pready low 3 ACCESS cycles, then high with prdata=0x12345678.
  - Response: rsp_rdata=0x12345678, rsp_wait=3; paddr stable throughout.
- Slave error:
  - Stimulus: read with pready=1, pslverr=1.
  - Response: rsp_slverr=1, rsp_timeout=0.
  - Also: pslverr=1 while pready=0 on earlier cycles is not reported when completion has pslverr=0.
- Timeout:
  - Stimulus: TIMEOUT=4, pready held 0.
  - Response: after 4 stalled ACCESS cycles, psel/penable drop; rsp_valid with rsp_timeout=1, slverr=1, rdata=0, wait=4.
- Back-to-back plus reset:
  - Stimulus: cmd_valid held high with 2 commands.
  - Response: one IDLE cycle between transfers.
  - Then: assert rst during ACCESS of a 3rd transfer → psel=penable=0 immediately, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB requester: takes one command at a time and runs its SETUP/ACCESS phases on the bus.
// The ACCESS phase can be cut short by a timeout on pready. Each transfer ends with a
// registered one-cycle response strobe.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // Command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  // Response port
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [31:0]       rsp_wait,
  // APB requester side
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_t;

  state_t              r_state;
  logic                r_psel;
  logic                r_penable;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [31:0]         r_wait;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_slverr;
  logic                r_rsp_timeout;
  logic [31:0]         r_rsp_wait;

  logic [31:0]         w_wait_inc;
  logic                w_timeout_hit;

  // Saturating stall count including the current ACCESS cycle.
  assign w_wait_inc    = (r_wait == 32'hFFFF_FFFF) ? r_wait : r_wait + 32'd1;
  // Abort on the stalled cycle that brings the count up to TIMEOUT, so the bus sees
  // exactly TIMEOUT stalled ACCESS cycles and the response reports wait == TIMEOUT.
  assign w_timeout_hit = (TIMEOUT != 0) && (w_wait_inc == 32'(TIMEOUT));

  assign cmd_ready   = (r_state == StIdle);
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_wait    = r_rsp_wait;

  // Transfer FSM with registered bus outputs and response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_wait        <= 32'd0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_wait    <= 32'd0;
    end else begin
      // Strobe lasts a single cycle; other response fields hold until the next response.
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cmd_valid) begin
            r_paddr  <= cmd_addr;
            r_pwrite <= cmd_write;
            r_pwdata <= cmd_wdata;
            r_wait   <= 32'd0;
            r_psel   <= 1'b1;
            r_state  <= StSetup;
          end
        end
        StSetup: begin
          // pready is not looked at here.
          r_penable <= 1'b1;
          r_state   <= StAccess;
        end
        StAccess: begin
          if (pready) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= StIdle;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_slverr  <= pslverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_wait    <= r_wait;
          end else if (w_timeout_hit) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= StIdle;
            r_wait        <= w_wait_inc;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_wait    <= w_wait_inc;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: the expected response is queued when a command
// is driven and is checked when rsp_valid fires. The slave side is scripted per transfer.
module tb_apb_master_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_write;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic [31:0]   rsp_wait;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
    logic [31:0] waitc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  apb_master_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .rsp_wait   (rsp_wait),
    .psel       (psel),
    .penable    (penable),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_slverr", 32'(rsp_slverr), 32'(e.slverr));
        check_eq("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
        check_eq("rsp_wait", rsp_wait, e.waitc);
      end
    end
  end

  // Runs one transfer starting at a negedge in IDLE; returns at the negedge of the
  // following IDLE cycle. hold keeps cmd_valid high (with junk payload) while busy.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input int nwait, input logic [31:0] rdata, input logic err,
                      input logic stall_err, input bit tmo, input bit hold);
    exp_t e;
    int   nstall;
    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = wdata;
    @(negedge clk);
    // SETUP: command payload changes must be ignored; pready high here is ignored too.
    cmd_valid = hold;
    cmd_addr  = ~addr;
    cmd_write = ~wr;
    cmd_wdata = ~wdata;
    pready    = 1'b1;
    pslverr   = 1'b1;
    prdata    = 32'hFFFF_0000;
    check_eq("setup_psel", 32'(psel), 32'd1);
    check_eq("setup_penable", 32'(penable), 32'd0);
    check_eq("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("setup_paddr", paddr, addr);
    check_eq("setup_pwrite", 32'(pwrite), 32'(wr));
    check_eq("setup_pwdata", pwdata, wdata);
    e.rdata  = (wr || tmo) ? 32'd0 : rdata;
    e.slverr = tmo ? 1'b1 : err;
    e.tmo    = tmo;
    e.waitc  = tmo ? 32'(TO) : 32'(nwait);
    exp_q.push_back(e);
    nstall = tmo ? int'(TO) : nwait;
    @(negedge clk);
    for (int i = 0; i < nstall; i++) begin
      check_eq("stall_psel", 32'(psel), 32'd1);
      check_eq("stall_penable", 32'(penable), 32'd1);
      check_eq("stall_paddr", paddr, addr);
      pready  = 1'b0;
      pslverr = stall_err;
      prdata  = $urandom;
      @(negedge clk);
    end
    if (!tmo) begin
      check_eq("access_penable", 32'(penable), 32'd1);
      check_eq("access_paddr", paddr, addr);
      check_eq("access_pwdata", pwdata, wdata);
      pready  = 1'b1;
      pslverr = err;
      prdata  = rdata;
      @(negedge clk);
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    check_eq("done_psel", 32'(psel), 32'd0);
    check_eq("done_penable", 32'(penable), 32'd0);
    check_eq("done_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("done_paddr_hold", paddr, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    #12;
    check_eq("rst_psel", 32'(psel), 32'd0);
    check_eq("rst_penable", 32'(penable), 32'd0);
    check_eq("rst_paddr", paddr, 32'd0);
    check_eq("rst_pwrite", 32'(pwrite), 32'd0);
    check_eq("rst_pwdata", pwdata, 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_slverr", 32'(rsp_slverr), 32'd0);
    check_eq("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check_eq("rst_rsp_wait", rsp_wait, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write; prdata is junk and must not appear in the response.
    xfer(32'h10, 1'b1, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0);
    // Response fields hold after the strobe.
    @(negedge clk);
    check_eq("hold_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("hold_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("hold_rsp_wait", rsp_wait, 32'd0);
    // Read with 3 wait states.
    xfer(32'h24, 1'b0, 32'h0, 3, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
    // Slave error on completion.
    xfer(32'h30, 1'b0, 32'h0, 0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0);
    // pslverr during stalls is ignored.
    xfer(32'h34, 1'b0, 32'h0, 2, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 1'b0);
    // Timeout with pready held low.
    xfer(32'h40, 1'b1, 32'h55, 0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Back-to-back with cmd_valid held high.
    xfer(32'h50, 1'b1, 32'h11111111, 1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    xfer(32'h54, 1'b0, 32'h0, 0, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during ACCESS of a third transfer.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h60;
    cmd_write = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_penable", 32'(penable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_psel", 32'(psel), 32'd0);
    check_eq("async_rst_penable", 32'(penable), 32'd0);
    check_eq("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    // The aborted read's expectation was never queued; any strobe now is flagged.
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      check_eq("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check_eq("pending_rsp", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
